// File: rtl/raster_frame_sequencer.sv
// raster_frame_sequencer: per-frame clear, triangle gating, drain and swap control.
// Optional drain watchdog: define RASTER_SEQ_WATCHDOG_EN.
module raster_frame_sequencer #(
   parameter logic CLEAR_ON_START  = 1'b1,
   parameter int   DRAIN_GUARD     = 2,
   parameter int   COUNT_BITS      = 16,
   parameter int   WATCHDOG_CYCLES = 1048576,
   parameter int   VTX_BITS        = 96
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic [VTX_BITS-1:0]   tri_v0,
   input  logic [VTX_BITS-1:0]   tri_v1,
   input  logic [VTX_BITS-1:0]   tri_v2,
   input  logic                  tri_last,
   input  logic                  tri_valid,
   output logic                  tri_ready,
   output logic [VTX_BITS-1:0]   rast_v0,
   output logic [VTX_BITS-1:0]   rast_v1,
   output logic [VTX_BITS-1:0]   rast_v2,
   output logic                  rast_valid,
   input  logic                  rast_ready,
   input  logic                  rast_busy,
   output logic                  clear_req,
   input  logic                  clear_done,
   output logic                  swap_req,
   input  logic                  swap_ack,
   output logic                  frame_active,
   output logic                  frame_done,
   output logic [COUNT_BITS-1:0] tri_count,
   output logic                  error
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_SWAP   = 3'd4;

   if (DRAIN_GUARD < 1 || DRAIN_GUARD > 15 || WATCHDOG_CYCLES < 1) begin : g_param_check
      $error("raster_frame_sequencer: DRAIN_GUARD or WATCHDOG_CYCLES out of range");
   end

   logic [2:0] state;
   logic [3:0] guard;
   logic       in_stream;
   logic       hs;
   logic       guard_hit;
   logic       wd_hit;

   assign in_stream    = (state == S_STREAM);
   assign rast_valid   = in_stream & tri_valid;
   assign tri_ready    = in_stream & rast_ready;
   assign hs           = rast_valid & rast_ready;
   assign rast_v0      = tri_v0;
   assign rast_v1      = tri_v1;
   assign rast_v2      = tri_v2;
   assign clear_req    = (state == S_CLEAR);
   assign swap_req     = (state == S_SWAP);
   assign frame_active = (state != S_IDLE);
   assign frame_done   = (state == S_SWAP) & swap_ack;

   // Guard is the count of idle cycles already seen; this cycle makes it DRAIN_GUARD.
   assign guard_hit = (state == S_DRAIN) & ~rast_busy
                    & (guard == 4'(DRAIN_GUARD - 1));

`ifdef RASTER_SEQ_WATCHDOG_EN
   localparam int WD_BITS = $clog2(WATCHDOG_CYCLES + 1);

   logic [WD_BITS-1:0] wd_cnt;
   logic               err_q;

   assign wd_hit = (state == S_DRAIN)
                 & (wd_cnt == WD_BITS'(WATCHDOG_CYCLES - 1));
   assign error  = err_q;

   // Held at zero outside DRAIN so every drain starts a fresh timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == S_DRAIN)
            wd_cnt <= wd_cnt + WD_BITS'(1);
         else
            wd_cnt <= '0;
         if (wd_hit && !guard_hit)
            err_q <= 1'b1;
      end
   end
`else
   assign wd_hit = 1'b0;
   assign error  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         guard     <= '0;
         tri_count <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (frame_start) begin
                  tri_count <= '0;
                  state     <= CLEAR_ON_START ? S_CLEAR : S_STREAM;
               end
            end
            S_CLEAR: begin
               if (clear_done)
                  state <= S_STREAM;
            end
            S_STREAM: begin
               if (hs && tri_count != '1)
                  tri_count <= tri_count + COUNT_BITS'(1);
               if (hs && tri_last) begin
                  guard <= '0;
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               guard <= rast_busy ? 4'd0 : guard + 4'd1;
               if (guard_hit || wd_hit)
                  state <= S_SWAP;
            end
            S_SWAP: begin
               if (swap_ack)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// tb_raster_frame_sequencer: table vectors, directed corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_raster_frame_sequencer;

   localparam int DG   = 2;
   localparam int CB   = 4;
   localparam int VW   = 32;
   localparam int WD   = 64;
   localparam int MAXC = (1 << CB) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic [VW-1:0] tri_v0 = '0, tri_v1 = '0, tri_v2 = '0;
   logic          tri_last = 1'b0;
   logic          tri_valid = 1'b0;
   logic          tri_ready;
   logic [VW-1:0] rast_v0, rast_v1, rast_v2;
   logic          rast_valid;
   logic          rast_ready = 1'b0;
   logic          rast_busy = 1'b0;
   logic          clear_req;
   logic          clear_done = 1'b0;
   logic          swap_req;
   logic          swap_ack = 1'b0;
   logic          frame_active;
   logic          frame_done;
   logic [CB-1:0] tri_count;
   logic          error;

   raster_frame_sequencer #(
      .CLEAR_ON_START (1'b1),
      .DRAIN_GUARD    (DG),
      .COUNT_BITS     (CB),
      .WATCHDOG_CYCLES(WD),
      .VTX_BITS       (VW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .tri_v0      (tri_v0),
      .tri_v1      (tri_v1),
      .tri_v2      (tri_v2),
      .tri_last    (tri_last),
      .tri_valid   (tri_valid),
      .tri_ready   (tri_ready),
      .rast_v0     (rast_v0),
      .rast_v1     (rast_v1),
      .rast_v2     (rast_v2),
      .rast_valid  (rast_valid),
      .rast_ready  (rast_ready),
      .rast_busy   (rast_busy),
      .clear_req   (clear_req),
      .clear_done  (clear_done),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .frame_active(frame_active),
      .frame_done  (frame_done),
      .tri_count   (tri_count),
      .error       (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic tv;
      logic rr;
      logic last;
      logic exp_tr;
      logic exp_rv;
      logic exp_inc;
   } vec_t;

   int   n_vec = 0;
   int   n_err = 0;
   bit   busy_q[$];
   bit   exp_err = 1'b0;
   vec_t tbl[10];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_vtx();
      tri_v0 = $urandom;
      tri_v1 = $urandom;
      tri_v2 = $urandom;
   endtask

   // Drain length: first cycle ending DG consecutive idle cycles (busy_q, then idle).
   function automatic int raw_drain();
      int run = 0;
      for (int k = 0; k < busy_q.size() + DG + 1; k++) begin
         bit b = (k < busy_q.size()) ? busy_q[k] : 1'b0;
         run = b ? 0 : run + 1;
         if (run >= DG) return k + 1;
      end
      return -1;
   endfunction

   function automatic int exp_drain();
      int r = raw_drain();
`ifdef RASTER_SEQ_WATCHDOG_EN
      if (r > WD) r = WD;
`endif
      return r;
   endfunction

   task automatic start_frame();
      frame_start = 1'b1;
      @(negedge clk);
      chk("idle_before_start", frame_active, 0);
      step();
      frame_start = 1'b0;
   endtask

   task automatic do_clear(input int dly);
      int cnt = 0;
      for (int i = 0; i < dly; i++) begin
         clear_done = (i == dly - 1);
         @(negedge clk);
         if (clear_req) cnt++;
         step();
      end
      clear_done = 1'b0;
      chk("clear_cycles", cnt, dly);
   endtask

   task automatic do_stream(input int n, input bit inject);
      int sent = 0;
      int cyc  = 0;
      while (sent < n && cyc < 400) begin
         tri_valid   = ($urandom_range(0, 3) != 0);
         rast_ready  = ($urandom_range(0, 3) != 0);
         tri_last    = (sent == n - 1);
         frame_start = inject && ($urandom_range(0, 7) == 0);
         clear_done  = inject && ($urandom_range(0, 7) == 0);
         rand_vtx();
         @(negedge clk);
         if (cyc == 0) chk("clear_req_drop", clear_req, 0);
         chk("rast_valid", rast_valid, tri_valid);
         chk("tri_ready", tri_ready, rast_ready);
         chk("rast_v0", rast_v0, tri_v0);
         chk("rast_v2", rast_v2, tri_v2);
         chk("stream_count", tri_count, (sent > MAXC) ? MAXC : sent);
         if (tri_valid && rast_ready) sent++;
         step();
         cyc++;
      end
      tri_valid   = 1'b0;
      tri_last    = 1'b0;
      frame_start = 1'b0;
      clear_done  = 1'b0;
      if (sent != n) chk("stream_budget", sent, n);
   endtask

   task automatic do_drain(input bit inject);
      int exp = exp_drain();
      int d   = 0;
      while (d <= exp + 5) begin
         rast_busy = (d < busy_q.size()) ? busy_q[d] : 1'b0;
         swap_ack  = inject && (d < exp) && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         if (swap_req) break;
         d++;
         step();
      end
      chk("drain_cycles", d, exp);
      step();
      rast_busy = 1'b0;
      swap_ack  = 1'b0;
`ifdef RASTER_SEQ_WATCHDOG_EN
      if (raw_drain() > WD) exp_err = 1'b1;
`endif
   endtask

   task automatic do_swap(input int ack_dly, input bit start_on_ack, input int n);
      for (int i = 0; i <= ack_dly; i++) begin
         swap_ack    = (i == ack_dly);
         frame_start = start_on_ack && (i == ack_dly);
         @(negedge clk);
         chk("swap_req", swap_req, 1);
         chk("frame_done", frame_done, swap_ack);
         step();
      end
      swap_ack    = 1'b0;
      frame_start = 1'b0;
      @(negedge clk);
      chk("idle_after_swap", frame_active, 0);
      chk("frame_done_pulse", frame_done, 0);
      chk("swap_req_drop", swap_req, 0);
      chk("final_count", tri_count, (n > MAXC) ? MAXC : n);
      chk("error_flag", error, exp_err);
      step();
   endtask

   task automatic run_frame(input int n, input int clr, input int ack,
                            input bit inject, input bit start_on_ack);
      start_frame();
      do_clear(clr);
      do_stream(n, inject);
      do_drain(inject);
      do_swap(ack, start_on_ack, n);
   endtask

   initial begin
      int cnt;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      @(negedge clk);
      chk("rst_active", frame_active, 0);
      chk("rst_clear_req", clear_req, 0);
      chk("rst_swap_req", swap_req, 0);
      chk("rst_count", tri_count, 0);
      chk("rst_error", error, 0);
      step();
      rst = 1'b0;
      step();

      // Basic frame: clear for 5 cycles, table-driven stream, busy 20 cycles.
      start_frame();
      do_clear(5);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tri_valid  = tbl[i].tv;
         rast_ready = tbl[i].rr;
         tri_last   = tbl[i].last;
         rand_vtx();
         @(negedge clk);
         chk("tbl_tri_ready", tri_ready, tbl[i].exp_tr);
         chk("tbl_rast_valid", rast_valid, tbl[i].exp_rv);
         chk("tbl_rast_v1", rast_v1, tri_v1);
         chk("tbl_count", tri_count, cnt);
         cnt += int'(tbl[i].exp_inc);
         step();
      end
      tri_valid = 1'b0;
      tri_last  = 1'b0;
      busy_q.delete();
      for (int i = 0; i < 20; i++) busy_q.push_back(1'b1);
      do_drain(1'b0);
      do_swap(0, 1'b0, 3);

      // Busy glitch 0,1,0,0.
      busy_q.delete();
      busy_q.push_back(1'b0);
      busy_q.push_back(1'b1);
      busy_q.push_back(1'b0);
      busy_q.push_back(1'b0);
      run_frame(1, 1, 1, 1'b0, 1'b0);

      // Ignored inputs, plus frame_start together with swap_ack.
      busy_q.delete();
      busy_q.push_back(1'b1);
      busy_q.push_back(1'b0);
      busy_q.push_back(1'b1);
      run_frame(5, 2, 2, 1'b1, 1'b1);

      // Reset mid-stream after two triangles.
      start_frame();
      do_clear(2);
      tri_valid  = 1'b1;
      rast_ready = 1'b1;
      step();
      step();
      chk("pre_rst_count", tri_count, 2);
      #2 rst = 1'b1;
      #1;
      chk("arst_active", frame_active, 0);
      chk("arst_count", tri_count, 0);
      chk("arst_tri_ready", tri_ready, 0);
      chk("arst_rast_valid", rast_valid, 0);
      chk("arst_clear_req", clear_req, 0);
      step();
      rst       = 1'b0;
      tri_valid = 1'b0;
      step();
      busy_q.delete();
      run_frame(1, 1, 0, 1'b0, 1'b0);

      // Randomized frames, including counts past saturation.
      for (int f = 0; f < 20; f++) begin
         busy_q.delete();
         for (int i = 0; i < $urandom_range(0, 8); i++)
            busy_q.push_back(1'($urandom_range(0, 1)));
         run_frame($urandom_range(1, 20), $urandom_range(1, 6),
                   $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
      end

`ifdef RASTER_SEQ_WATCHDOG_EN
      busy_q.delete();
      for (int i = 0; i < 90; i++) busy_q.push_back(1'b1);
      run_frame(2, 1, 0, 1'b0, 1'b0);
      busy_q.delete();
      run_frame(1, 1, 0, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
